stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Run-control sequencer for the two-digit seconds display. It takes single-cycle, already-debounced key pulses for start/stop and lap/reset, and runs a four-state controller. It owns the prescaler that derives the one-second tick and the BCD seconds counter that the tick advances. Its two BCD digit outputs feed the existing 7-segment lookup (tens digit to `seg_led_1`, ones digit to `seg_led_2`).

## Interface

Parameters:
- `DIV_NUM`, default 12_000_000: clock cycles per count tick. Legal range is ≥ 2.
- `WRAP`, default 20: the counter runs from 0 to WRAP-1, then returns to 0. Legal range is 1..100.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start_pulse`, in, 1: one-cycle pulse from the debouncer for the start/stop key.
- `lap_pulse`, in, 1: one-cycle pulse from the debouncer for the lap/reset key.
- `disp_tens`, out, 4: BCD tens digit to display.
- `disp_ones`, out, 4: BCD ones digit to display.
- `running`, out, 1: high in RUN and LAP.
- `lap_active`, out, 1: high in LAP (display frozen).
- `tick`, out, 1: one-cycle pulse on every counter increment.

## Operation

- **States:** IDLE, RUN, PAUSE, LAP. Encoding is free. The state register is the only source of `running` and `lap_active`.
- **Transitions** (evaluated on each `clk` edge):
  - IDLE: `start_pulse` → RUN. `lap_pulse` is ignored.
  - RUN: `start_pulse` → PAUSE. `lap_pulse` → LAP and latches `lap_reg <= count`.
  - LAP: `start_pulse` → PAUSE (display returns to the live value). `lap_pulse` → RUN (display released).
  - PAUSE: `start_pulse` → RUN. `lap_pulse` → IDLE, which clears the count, `lap_reg` and the prescaler.
  - Both pulses in the same cycle: `start_pulse` wins and `lap_pulse` is dropped.
- **Prescaler:** `presc` is ceil(log2(DIV_NUM)) bits wide.
  - In RUN/LAP it counts 0..DIV_NUM-1 and wraps.
  - In PAUSE it holds its value, so a resume continues the partial second.
  - In IDLE it is 0.
- **Tick:** `tick = (state ∈ {RUN, LAP}) && (presc == DIV_NUM-1)`. The gating uses the current registered state, so a tick coinciding with a stop pulse still increments.
- **Counter:** two BCD registers, `cnt_tens` and `cnt_ones`, updated on each tick:
  - If `{tens, ones}` equals WRAP-1 → 00.
  - Else if ones == 9 → ones = 0, tens + 1.
  - Else ones + 1.
  - Never uses binary `/` or `%`.
- **Lap capture:** `lap_reg` takes the pre-increment count when the lap pulse coincides with a tick.
- **Display:** `disp_{tens,ones} = lap_active ? lap_reg : cnt`. This is a combinational mux of registers only.
- **Reset:** asserting `rst_n` low at any time, including mid-second or in LAP, forces immediately:
  - state IDLE;
  - `presc`, `cnt` and `lap_reg` all 0;
  - all outputs 0: `disp_tens` = 0, `disp_ones` = 0, `running` = 0, `lap_active` = 0, `tick` = 0.

## Timing

- A key pulse sampled at edge n changes `running`/`lap_active` after edge n; this is visible in cycle n+1.
- First tick after IDLE→RUN at edge n: asserted in cycle n+DIV_NUM, and the count becomes 1 after edge n+DIV_NUM.
- `tick` width is exactly one cycle. The tick period is exactly DIV_NUM cycles while running.
- The display follows the counter in the cycle after a tick edge. In LAP it is constant until exit.
- Pulses wider than one cycle are outside the contract; the debouncer guarantees single-cycle pulses.

## Test plan

- **Reset/start:** DIV_NUM=4, WRAP=20. Release reset, pulse start.
  - `running`=1 in the next cycle.
  - `tick` every 4 cycles.
  - Display reads 01, 02, … 09, 10 (BCD carry).
- **Wrap:** run 20 ticks → display shows 19 then 00. Also run with WRAP=1 → the display stays at 00 while ticks continue.
- **Pause/resume:** stop with `presc`=2 → display and `presc` hold for 50 cycles. Start again → the next tick arrives 2 cycles later, not 4.
- **Lap:**
  - Lap at count 07 → display frozen at 07 while the internal count reaches 12.
  - Lap again → display 12 (or the current value).
  - Lap at count 07 coinciding with a tick → `lap_reg`=07 and cnt=08.
- **Clear and collisions:**
  - PAUSE + lap → IDLE with display 00.
  - In IDLE, a lap pulse alone causes no change.
  - Start and lap in the same cycle from RUN → PAUSE, `lap_active`=0.
- **Async reset mid-LAP:** drop `rst_n` between clock edges → all outputs 0 and state IDLE without waiting for a clock edge. After release, start → count begins again from 00.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: IDLE/RUN/PAUSE/LAP controller, one-second
// prescaler and two-digit BCD seconds counter with a lap-freeze display mux.
module stopwatch_ctrl #(
  parameter int DIV_NUM = 12_000_000,
  parameter int WRAP    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_pulse,
  input  logic       lap_pulse,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       running,
  output logic       lap_active,
  output logic       tick
);

  localparam int PW = $clog2(DIV_NUM);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_NUM - 1);
  // Last count value split into BCD digits; evaluated once at elaboration.
  localparam logic [3:0] LAST_TENS = 4'((WRAP - 1) / 10);
  localparam logic [3:0] LAST_ONES = 4'((WRAP - 1) % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    cnt_tens, cnt_ones;
  logic [3:0]    lap_tens, lap_ones;
  logic          clear;

  // Status flags and tick are pure decodes of registers, so they drop the
  // instant the asynchronous reset forces the registers to zero.
  assign running    = (state == RUN) || (state == LAP);
  assign lap_active = (state == LAP);
  assign tick       = running && (presc == PRESC_MAX);
  // Lap key in PAUSE returns to IDLE and wipes everything; start has priority.
  assign clear      = (state == PAUSE) && lap_pulse && !start_pulse;

  // Controller state and lap capture register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lap_tens <= '0;
      lap_ones <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pulse) state <= RUN;
        end
        RUN: begin
          if (start_pulse) begin
            state <= PAUSE;
          end else if (lap_pulse) begin
            state    <= LAP;
            // Pre-increment value, even when a tick lands on this edge.
            lap_tens <= cnt_tens;
            lap_ones <= cnt_ones;
          end
        end
        LAP: begin
          if (start_pulse)    state <= PAUSE;
          else if (lap_pulse) state <= RUN;
        end
        PAUSE: begin
          if (start_pulse) begin
            state <= RUN;
          end else if (lap_pulse) begin
            state    <= IDLE;
            lap_tens <= '0;
            lap_ones <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prescaler: counts while running, holds in PAUSE so a resume finishes the
  // partial second, and sits at zero in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (running) begin
      presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
    end else if ((state == IDLE) || clear) begin
      presc <= '0;
    end
  end

  // BCD seconds counter advanced by tick; tick gating uses the current state,
  // so a tick that coincides with a stop pulse still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_tens <= '0;
      cnt_ones <= '0;
    end else if (clear) begin
      cnt_tens <= '0;
      cnt_ones <= '0;
    end else if (tick) begin
      if ((cnt_tens == LAST_TENS) && (cnt_ones == LAST_ONES)) begin
        cnt_tens <= '0;
        cnt_ones <= '0;
      end else if (cnt_ones == 4'd9) begin
        cnt_ones <= '0;
        cnt_tens <= cnt_tens + 4'd1;
      end else begin
        cnt_ones <= cnt_ones + 4'd1;
      end
    end
  end

  // Display shows the frozen lap value in LAP, otherwise the live count.
  assign disp_tens = lap_active ? lap_tens : cnt_tens;
  assign disp_ones = lap_active ? lap_ones : cnt_ones;

endmodule
